// File: rtl/counter_down_3bit_timer.sv
// counter_down_3bit_timer
// Loadable down counter / interval timer with optional auto-reload.
// It counts a loaded value down to zero and emits a one-cycle underflow pulse.
// In one-shot mode it then parks in DONE. In auto-reload mode it restarts from
// the last loaded value.
//
// Optional feature macro: COUNTER_DOWN_PRESCALE_EN
//   When defined, a prescale_in port and a PRESCALE_W-bit prescaler are added.
//   A count tick then occurs once per (prescale_in+1) enabled cycles in RUN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; count holds, ticks ignored until a load
// RUN   | counting down on each tick; busy_out high
// DONE  | one-shot finished at zero; done_out high until next load

module counter_down_3bit_timer #(
    parameter int WIDTH      = 3,
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             reset_al_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load_in,
    input  logic             enable_in,
    input  logic             auto_reload_in,
`ifdef COUNTER_DOWN_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_in,
`endif
    output logic [WIDTH-1:0] count_out,
    output logic             underflow_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             zero_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_underflow;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_underflow_nxt;
    logic             w_tick;
    logic             w_count_zero;

`ifdef COUNTER_DOWN_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_presc_nxt;

    // Prescaler: a tick fires when the prescaler has run out, and then it reloads.
    always_comb begin
        w_presc_nxt = r_presc;
        w_tick      = 1'b0;
        if (load_in) begin
            w_presc_nxt = prescale_in;
        end else if (r_state == ST_RUN && enable_in) begin
            if (r_presc == '0) begin
                w_tick      = 1'b1;
                w_presc_nxt = prescale_in;
            end else begin
                w_presc_nxt = r_presc - 1'b1;
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_presc_nxt;
        end
    end
`else
    // Without the prescaler, every enabled cycle is a tick.
    always_comb begin
        w_tick = enable_in;
    end
`endif

    assign w_count_zero = (r_count == '0);

    // Next-state and datapath decode: load beats tick, tick beats hold.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_reload_nxt    = r_reload;
        w_underflow_nxt = 1'b0;
        if (load_in) begin
            w_state_nxt  = ST_RUN;
            w_count_nxt  = d_in;
            w_reload_nxt = d_in;
        end else if (r_state == ST_RUN && w_tick) begin
            if (!w_count_zero) begin
                w_count_nxt = r_count - 1'b1;
            end else begin
                w_underflow_nxt = 1'b1;
                if (auto_reload_in) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
        end
    end

    // State, count, reload value and underflow pulse registers.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_reload    <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_reload    <= w_reload_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign count_out     = r_count;
    assign underflow_out = r_underflow;
    assign busy_out      = (r_state == ST_RUN);
    assign done_out      = (r_state == ST_DONE);
    assign zero_out      = w_count_zero;

endmodule

// File: tb/tb_counter_down_3bit_timer.sv
// Testbench for counter_down_3bit_timer.
// The reference model tracks the number of ticks remaining until the next
// underflow, not the count itself. The displayed count is derived from that.
module tb_counter_down_3bit_timer;

    localparam int WIDTH      = 3;
    localparam int PRESCALE_W = 4;

    logic             clk = 1'b0;
    logic             reset_al_in;
    logic [WIDTH-1:0] d_in;
    logic             load_in;
    logic             enable_in;
    logic             auto_reload_in;
`ifdef COUNTER_DOWN_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_in;
`endif
    logic [WIDTH-1:0] count_out;
    logic             underflow_out;
    logic             busy_out;
    logic             done_out;
    logic             zero_out;

    counter_down_3bit_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk            (clk),
        .reset_al_in    (reset_al_in),
        .d_in           (d_in),
        .load_in        (load_in),
        .enable_in      (enable_in),
        .auto_reload_in (auto_reload_in),
`ifdef COUNTER_DOWN_PRESCALE_EN
        .prescale_in    (prescale_in),
`endif
        .count_out      (count_out),
        .underflow_out  (underflow_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .zero_out       (zero_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = idle, 1 = running, 2 = finished.
    int m_mode;
    int m_left;     // ticks still needed before the next underflow (running only)
    int m_hold;     // count shown while not running
    int m_reload;
    int m_uf;
    int m_presc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        return (m_mode == 1) ? (m_left - 1) : m_hold;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_hold = 0; m_reload = 0; m_uf = 0; m_presc = 0;
    endtask

    task automatic model_edge();
        int tick;
        m_uf = 0;
        if (!reset_al_in) begin
            model_reset();
        end else if (load_in) begin
            m_mode   = 1;
            m_reload = int'(d_in);
            m_left   = m_reload + 1;
`ifdef COUNTER_DOWN_PRESCALE_EN
            m_presc  = int'(prescale_in);
`endif
        end else if (m_mode == 1) begin
            tick = enable_in ? 1 : 0;
`ifdef COUNTER_DOWN_PRESCALE_EN
            if (enable_in) begin
                if (m_presc == 0) m_presc = int'(prescale_in);
                else begin m_presc = m_presc - 1; tick = 0; end
            end
`endif
            if (tick == 1) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_uf = 1;
                    if (auto_reload_in) m_left = m_reload + 1;
                    else begin m_mode = 2; m_hold = 0; end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count_out), 32'(m_count()));
        chk({tag, ".uf"},    32'(underflow_out), 32'(m_uf));
        chk({tag, ".busy"},  32'(busy_out), 32'(m_mode == 1));
        chk({tag, ".done"},  32'(done_out), 32'(m_mode == 2));
        chk({tag, ".zero"},  32'(zero_out), 32'(m_count() == 0));
    endtask

    // One clock: the model follows the edge and the outputs are checked 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic ld, input int d, input logic en, input logic ar);
        load_in = ld; d_in = WIDTH'(d); enable_in = en; auto_reload_in = ar;
    endtask

    int exp_ar_c[9]  = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    int exp_ar_u[9]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    int exp_os_c[4]  = '{3, 2, 1, 0};
    int exp_en_c[4]  = '{4, 4, 3, 3};

    initial begin
        model_reset();
        reset_al_in = 1'b0;
        set_in(1'b0, 0, 1'b0, 1'b0);
`ifdef COUNTER_DOWN_PRESCALE_EN
        prescale_in = '0;
`endif
        // Reset held for two cycles.
        step("rst");
        step("rst");
        chk("rst.count_const", 32'(count_out), 32'd0);
        chk("rst.zero_const", 32'(zero_out), 32'd1);
        #2; reset_al_in = 1'b1;

        // One-shot from 3.
        set_in(1'b1, 3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("oneshot");
            chk("oneshot.seq", 32'(count_out), 32'(exp_os_c[i]));
            set_in(1'b0, 0, 1'b1, 1'b0);
        end
        step("oneshot_uf");
        chk("oneshot.uf_const", 32'(underflow_out), 32'd1);
        chk("oneshot.done_const", 32'(done_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step("oneshot_hold");
            chk("oneshot.hold_count", 32'(count_out), 32'd0);
        end

        // Auto-reload from 2 over nine cycles.
        set_in(1'b1, 2, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step("autoreload");
            chk("autoreload.seq", 32'(count_out), 32'(exp_ar_c[i]));
            chk("autoreload.uf_seq", 32'(underflow_out), 32'(exp_ar_u[i]));
            set_in(1'b0, 0, 1'b1, 1'b1);
        end

        // Enable gating, then a load coinciding with a tick at zero.
        set_in(1'b1, 5, 1'b1, 1'b0);
        step("en_load");
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 0, (i % 2 == 0), 1'b0);
            step("en_gate");
            chk("en_gate.seq", 32'(count_out), 32'(exp_en_c[i]));
        end
        set_in(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("en_down");
        chk("collide.pre_zero", 32'(count_out), 32'd0);
        set_in(1'b1, 7, 1'b1, 1'b0);
        step("collide");
        chk("collide.count", 32'(count_out), 32'd7);
        chk("collide.uf", 32'(underflow_out), 32'd0);

        // Load with zero: underflow on the very next tick.
        set_in(1'b1, 0, 1'b1, 1'b0);
        step("load0");
        set_in(1'b0, 0, 1'b1, 1'b0);
        step("load0_uf");
        chk("load0.uf_const", 32'(underflow_out), 32'd1);

        // Async reset in the middle of a run.
        set_in(1'b1, 6, 1'b1, 1'b0);
        step("arst_load");
        set_in(1'b0, 0, 1'b1, 1'b0);
        step("arst_run");
        step("arst_run");
        chk("arst.pre_count", 32'(count_out), 32'd4);
        #2; reset_al_in = 1'b0; model_reset(); #1;
        check_all("arst_now");
        chk("arst.busy_const", 32'(busy_out), 32'd0);
        #2; reset_al_in = 1'b1;
        for (int i = 0; i < 3; i++) step("arst_after");
        chk("arst.idle_count", 32'(count_out), 32'd0);

`ifdef COUNTER_DOWN_PRESCALE_EN
        // Prescale of 2: one tick every three enabled cycles.
        prescale_in = 4'd2;
        set_in(1'b1, 1, 1'b1, 1'b0);
        step("presc_load");
        set_in(1'b0, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step("presc");
            chk("presc.uf_cycle", 32'(underflow_out), 32'(i == 6));
        end
`endif

        // Randomized traffic against the model, with rare mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
`ifdef COUNTER_DOWN_PRESCALE_EN
            if ($urandom_range(0, 15) == 0) prescale_in = PRESCALE_W'($urandom_range(0, 3));
`endif
            if ($urandom_range(0, 99) == 0) begin
                #2; reset_al_in = 1'b0; model_reset(); #1;
                check_all("rnd_arst");
                #1; reset_al_in = 1'b1;
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
